elevator_ctrl: RTL and testbench

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

---
 rtl/elevator_pkg.sv | 19 +
 rtl/sync2.sv | 24 ++
 rtl/elevator_ctrl.sv | 111 +++++++++++
 tb/tb_elevator_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller: default floor count,
// floor-index width and the FSM state encoding.
package elevator_pkg;

  localparam int NUM_FLOORS_DEF = 4;

  // Width of a floor index; never zero, even for a single-floor build.
  function automatic int floorWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FLOOR_W = floorWidth(NUM_FLOORS_DEF);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DOOR   = 2'd1;
  localparam logic [1:0] ST_MOVE   = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/elevator_ctrl.sv
// Single-car elevator controller: latches floor calls, serves them in the
// current travel direction first, and drives an external seconds counter.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int         NUM_FLOORS  = NUM_FLOORS_DEF,
  parameter logic [7:0] DOOR_SECS   = 8'd5,
  parameter logic [7:0] TRAVEL_SECS = 8'd3,
  localparam int        FW          = floorWidth(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  timer_done,
  output logic                  timer_en,
  output logic [7:0]            timer_seconds,
  output logic [FW-1:0]         cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  logic [1:0]            state_q, state_d;
  logic [FW-1:0]         floor_q, floor_d;
  logic                  dir_q, dir_d;
  logic [NUM_FLOORS-1:0] pend_q, pend_d;
  logic                  done_s;
  logic                  reqAbove, reqBelow;
  logic                  atTop, atBottom;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (timer_done),
    .q     (done_s)
  );

  always_comb begin
    reqAbove = 1'b0;
    reqBelow = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(floor_q)) reqAbove = reqAbove | pend_q[i];
      if (i < int'(floor_q)) reqBelow = reqBelow | pend_q[i];
    end
  end

  assign atTop    = (int'(floor_q) >= NUM_FLOORS - 1);
  assign atBottom = (floor_q == '0);

  // Clearing pending[cur_floor] on DOOR entry takes priority over a
  // simultaneous call; while the door is open that call is ignored.
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    pend_d  = pend_q | call_req;
    if (state_q == ST_DOOR) pend_d[floor_q] = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q[floor_q]) begin
          state_d         = ST_DOOR;
          pend_d[floor_q] = 1'b0;
        end else if (dir_q ? reqAbove : reqBelow) begin
          state_d = ST_MOVE;
        end else if (dir_q ? reqBelow : reqAbove) begin
          dir_d   = ~dir_q;
          state_d = ST_MOVE;
        end
      end
      ST_DOOR: begin
        if (done_s) state_d = ST_SETTLE;
      end
      ST_MOVE: begin
        if (done_s) begin
          if (dir_q && !atTop)         floor_d = floor_q + 1'b1;
          else if (!dir_q && !atBottom) floor_d = floor_q - 1'b1;
          state_d = ST_SETTLE;
        end
      end
      default: begin
        // SETTLE holds the counter enable low until the stale done clears.
        if (!done_s) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      floor_q <= '0;
      dir_q   <= 1'b1;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
    end
  end

  assign timer_en      = (state_q == ST_DOOR) || (state_q == ST_MOVE);
  assign timer_seconds = (state_q == ST_DOOR) ? DOOR_SECS :
                         (state_q == ST_MOVE) ? TRAVEL_SECS : 8'd0;
  assign moving        = (state_q == ST_MOVE);
  assign door_open     = (state_q == ST_DOOR);
  assign cur_floor     = floor_q;
  assign dir_up        = dir_q;
  assign pending       = pend_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with a simple seconds-counter model that
// can be forced to hold its done flag high.
module tb_elevator_ctrl;
  import elevator_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [3:0]           call_req = 4'b0000;
  logic                 timer_done;
  logic                 timer_en;
  logic [7:0]           timer_seconds;
  logic [FLOOR_W-1:0]   cur_floor;
  logic                 dir_up;
  logic                 moving;
  logic                 door_open;
  logic [3:0]           pending;

  logic                 forceDone = 1'b0;
  logic [7:0]           cnt = 8'd0;
  int                   total = 0;
  int                   passed = 0;

  elevator_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .call_req      (call_req),
    .timer_done    (timer_done),
    .timer_en      (timer_en),
    .timer_seconds (timer_seconds),
    .cur_floor     (cur_floor),
    .dir_up        (dir_up),
    .moving        (moving),
    .door_open     (door_open),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  // Seconds counter: one tick per clock, cleared while the enable is low.
  always @(posedge clk) begin
    if (!timer_en) cnt <= 8'd0;
    else if (cnt != 8'hFF) cnt <= cnt + 8'd1;
  end

  assign timer_done = forceDone | (timer_en && timer_seconds != 8'd0 && cnt >= timer_seconds);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return moving;
      1:       return door_open;
      default: return timer_en;
    endcase
  endfunction

  task automatic waitSig(input int which, input logic val, input int budget, input string tag);
    int n = 0;
    while (pick(which) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {31'd0, pick(which)}, {31'd0, val});
  endtask

  task automatic applyStimulus(input logic [3:0] v);
    @(negedge clk);
    call_req = v;
    @(negedge clk);
    call_req = 4'b0000;
  endtask

  initial begin
    int reopen;
    int enSeen;

    // Reset state and idle with no calls
    repeat (3) @(negedge clk);
    checkOutput("rst_floor", cur_floor, 0);
    checkOutput("rst_dir", dir_up, 1);
    checkOutput("rst_outs", {timer_en, moving, door_open, timer_seconds}, 0);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("idle_en", timer_en, 0);
    checkOutput("idle_pend", pending, 0);
    checkOutput("idle_floor", cur_floor, 0);

    // Call floor 2 from floor 0
    applyStimulus(4'b0100);
    checkOutput("c2_pend", pending, 4'b0100);
    waitSig(0, 1'b1, 10, "c2_mv1_start");
    checkOutput("c2_mv1_secs", timer_seconds, 3);
    checkOutput("c2_mv1_floor", cur_floor, 0);
    waitSig(0, 1'b0, 20, "c2_mv1_end");
    checkOutput("c2_floor1", cur_floor, 1);
    checkOutput("c2_settle_en", timer_en, 0);
    waitSig(0, 1'b1, 20, "c2_mv2_start");
    checkOutput("c2_mv2_secs", timer_seconds, 3);
    waitSig(0, 1'b0, 20, "c2_mv2_end");
    checkOutput("c2_floor2", cur_floor, 2);
    waitSig(1, 1'b1, 20, "c2_door");
    checkOutput("c2_door_secs", timer_seconds, 5);
    checkOutput("c2_door_pend", pending, 0);
    waitSig(1, 1'b0, 30, "c2_door_close");

    // Calls above and below at floor 2 going up: floor 3 first
    applyStimulus(4'b1001);
    checkOutput("ud_pend", pending, 4'b1001);
    waitSig(1, 1'b1, 40, "ud_door3");
    checkOutput("ud_floor3", cur_floor, 3);
    checkOutput("ud_pend3", pending, 4'b0001);
    waitSig(0, 1'b1, 40, "ud_down_start");
    checkOutput("ud_dir_down", dir_up, 0);
    waitSig(1, 1'b1, 120, "ud_door0");
    checkOutput("ud_floor0", cur_floor, 0);
    checkOutput("ud_pend0", pending, 0);
    waitSig(1, 1'b0, 30, "ud_door0_close");

    // Held call at the open door's floor is ignored
    applyStimulus(4'b0010);
    waitSig(1, 1'b1, 40, "hc_door1");
    checkOutput("hc_floor1", cur_floor, 1);
    checkOutput("hc_dir_up", dir_up, 1);
    call_req = 4'b0010;
    repeat (3) @(negedge clk);
    checkOutput("hc_pend_masked", pending, 0);
    call_req = 4'b0000;
    waitSig(1, 1'b0, 30, "hc_door_close");
    reopen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (door_open) reopen++;
    end
    checkOutput("hc_no_reopen", reopen, 0);

    // Done held high across SETTLE
    applyStimulus(4'b0100);
    waitSig(0, 1'b1, 20, "fd_move");
    forceDone = 1'b1;
    waitSig(0, 1'b0, 10, "fd_move_end");
    checkOutput("fd_floor2", cur_floor, 2);
    enSeen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (timer_en || door_open || moving) enSeen++;
    end
    checkOutput("fd_settle_hold", enSeen, 0);
    checkOutput("fd_floor_hold", cur_floor, 2);
    forceDone = 1'b0;
    waitSig(1, 1'b1, 20, "fd_door");
    checkOutput("fd_door_floor", cur_floor, 2);
    waitSig(1, 1'b0, 30, "fd_door_close");

    // Reset mid-MOVE at floor 1 heading up
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(4'b1000);
    waitSig(0, 1'b1, 10, "rm_mv1");
    waitSig(0, 1'b0, 20, "rm_mv1_end");
    waitSig(0, 1'b1, 20, "rm_mv2");
    checkOutput("rm_floor1", cur_floor, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("rm_floor", cur_floor, 0);
    checkOutput("rm_outs", {timer_en, moving, door_open, pending}, 0);
    checkOutput("rm_dir", dir_up, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("rm_stay_idle", {moving, door_open, pending, cur_floor}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
